// File: rtl/bit_stitcher_pkg.sv
// Shared widths, state encoding and insert-mask helpers for the bit stitcher.
package bit_stitcher_pkg;

    localparam int unsigned CODE_W = 32;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned FILL_W = 7;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len;
    endfunction

    // Keeps only the low 'len' bits of a code; len is already clamped to 0..32.
    function automatic logic [CODE_W-1:0] insert_mask(input logic [LEN_W-1:0] len);
        if (len >= LEN_W'(CODE_W))
            return '1;
        else
            return (CODE_W'(1) << len) - CODE_W'(1);
    endfunction

endpackage

// File: rtl/bit_stitcher.sv
// Packs variable-length LSB-first codes into 32-bit words, flushing a final
// partial word with a byte count once the last code has been accepted.
module bit_stitcher
    import bit_stitcher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [2:0]        out_bytes
);

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [FILL_W-1:0]   r_fill;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic [2:0]          r_out_bytes;
    logic [CODE_W-1:0]   r_out_data;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [LEN_W-1:0]    w_len;
    logic [ACC_W-1:0]    w_code;
    logic [ACC_W-1:0]    w_acc_nx;
    logic [FILL_W-1:0]   w_fill_nx;
    state_t              w_state_nx;
    logic                w_ready_nx;
    logic                w_valid_nx;
    logic                w_last_nx;
    logic [2:0]          w_bytes_nx;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_len      = clamp_len(in_len);
        w_code     = {{(ACC_W-CODE_W){1'b0}}, in_data & insert_mask(w_len)};
        w_acc_nx   = r_acc;
        w_fill_nx  = r_fill;
        w_state_nx = r_state;

        if (w_out_xfer) begin
            if (r_out_last) begin
                w_acc_nx   = '0;
                w_fill_nx  = '0;
                w_state_nx = RUN;
            end else begin
                w_acc_nx  = r_acc >> CODE_W;
                w_fill_nx = r_fill - FILL_W'(CODE_W);
            end
        end

        // New bits land on top of the (possibly already shifted) accumulator.
        if (w_in_xfer) begin
            w_acc_nx  = w_acc_nx | (w_code << w_fill_nx);
            w_fill_nx = w_fill_nx + FILL_W'(w_len);
            if (in_last)
                w_state_nx = DRAIN;
        end

        w_ready_nx = (w_state_nx == RUN) && (w_fill_nx <= FILL_W'(CODE_W));
        w_valid_nx = (w_state_nx == DRAIN) || (w_fill_nx > FILL_W'(CODE_W));
        w_last_nx  = (w_state_nx == DRAIN) && (w_fill_nx <= FILL_W'(CODE_W));
        if (!w_valid_nx)
            w_bytes_nx = 3'd0;
        else if (w_last_nx)
            w_bytes_nx = 3'((w_fill_nx + FILL_W'(7)) >> 3);
        else
            w_bytes_nx = 3'd4;
    end

    // Handshake outputs are precomputed from next-state so they leave flops directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_fill      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_bytes <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_fill      <= w_fill_nx;
            r_in_ready  <= w_ready_nx;
            r_out_valid <= w_valid_nx;
            r_out_last  <= w_last_nx;
            r_out_bytes <= w_bytes_nx;
            r_out_data  <= w_acc_nx[CODE_W-1:0];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_bytes = r_out_bytes;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_bit_stitcher.sv
// Directed and randomized checks of bit_stitcher against hand values and a bit-queue model.
module tb_bit_stitcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [5:0]  in_len;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [2:0]  out_bytes;

    int n_tests = 0;
    int n_fail  = 0;

    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;

    logic [31:0] cq_d[$];
    logic [2:0]  cq_b[$];
    logic        cq_l[$];
    bit          mq[$];

    always #5 clk = ~clk;

    bit_stitcher dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_bytes (out_bytes)
    );

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            cq_d.push_back(out_data);
            cq_b.push_back(out_bytes);
            cq_l.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic [5:0] l, input logic last);
        int n;
        int unsigned lc;
        in_data  = d;
        in_len   = l;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(negedge clk);
            lc = (l > 6'd32) ? 32 : int'(l);
            for (int unsigned i = 0; i < lc; i++) mq.push_back(d[i]);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [2:0] b, input logic l);
        int n;
        n = 0;
        while (cq_d.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cq_d.size() == 0) begin
            chk({tag, "_timeout"}, 64'(cq_d.size()), 64'd1);
        end else begin
            chk({tag, "_data"},  64'(cq_d.pop_front()), 64'(d));
            chk({tag, "_bytes"}, 64'(cq_b.pop_front()), 64'(b));
            chk({tag, "_last"},  64'(cq_l.pop_front()), 64'(l));
        end
    endtask

    task automatic check_model(input string tag);
        int total;
        int idx;
        int rem;
        int take;
        logic [31:0] w;
        total = mq.size();
        if (total == 0) begin
            expect_word(tag, 32'h0, 3'd0, 1'b1);
        end else begin
            idx = 0;
            while (idx < total) begin
                rem  = total - idx;
                take = (rem > 32) ? 32 : rem;
                w = '0;
                for (int j = 0; j < take; j++) w[j] = mq[idx + j];
                expect_word(tag, w, (rem > 32) ? 3'd4 : 3'((take + 7) / 8), rem <= 32);
                idx += take;
            end
        end
        mq.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_bytes", 64'(out_bytes), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Four bytes then a single last bit.
        mq.delete();
        repeat (4) send(32'h7F, 6'd8, 1'b0);
        send(32'h1, 6'd1, 1'b1);
        expect_word("t7f_w0", 32'h7F7F7F7F, 3'd4, 1'b0);
        expect_word("t7f_w1", 32'h00000001, 3'd1, 1'b1);

        // Empty stream yields exactly one zero word.
        mq.delete();
        send(32'hDEADBEEF, 6'd0, 1'b1);
        expect_word("tempty", 32'h0, 3'd0, 1'b1);
        repeat (6) @(negedge clk);
        chk("tempty_extra", 64'(cq_d.size()), 64'd0);

        // 9-bit codes with garbage above bit 8.
        mq.delete();
        repeat (8) send(32'hFFFFFFFF, 6'd9, 1'b0);
        send(32'hFFFFFFFF, 6'd0, 1'b1);
        expect_word("t9_w0", 32'hFFFFFFFF, 3'd4, 1'b0);
        expect_word("t9_w1", 32'hFFFFFFFF, 3'd4, 1'b0);
        expect_word("t9_w2", 32'h000000FF, 3'd1, 1'b1);

        // Length above 32 clamps; exactly 32 buffered bits make a final full word.
        mq.delete();
        send(32'hFFFFFFFF, 6'd40, 1'b1);
        expect_word("tclamp", 32'hFFFFFFFF, 3'd4, 1'b1);

        // Backpressure with 40 bits buffered.
        mq.delete();
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        repeat (5) send(32'hAB, 6'd8, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data",  64'(out_data),  64'hABABABAB);
            @(negedge clk);
        end
        chk("bp_no_xfer", 64'(cq_d.size()), 64'd0);
        rdy_fixed = 1'b1;
        expect_word("bp_w0", 32'hABABABAB, 3'd4, 1'b0);
        send(32'hCD, 6'd8, 1'b0);
        send(32'h1, 6'd1, 1'b1);
        expect_word("bp_w1", 32'h0001CDAB, 3'd3, 1'b1);

        // Reset while draining 20 bits.
        mq.delete();
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send(32'hFFFFFFFF, 6'd20, 1'b1);
        chk("drst_valid_before", 64'(out_valid), 64'd1);
        chk("drst_last_before",  64'(out_last),  64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("drst_out_valid", 64'(out_valid), 64'd0);
        chk("drst_in_ready",  64'(in_ready),  64'd1);
        chk("drst_no_word",   64'(cq_d.size()), 64'd0);
        rdy_fixed = 1'b1;
        mq.delete();
        send(32'hFFFFFFFA, 6'd4, 1'b1);
        expect_word("drst_after", 32'h0000000A, 3'd1, 1'b1);

        // Random lengths, data and downstream stalls against the bit model.
        for (int s = 0; s < 3; s++) begin
            mq.delete();
            rdy_rand = 1'b1;
            for (int k = 0; k < 40; k++)
                send($urandom, 6'($urandom_range(0, 32)), k == 39);
            check_model("rand");
            rdy_rand = 1'b0;
            repeat (4) @(negedge clk);
            chk("rand_extra", 64'(cq_d.size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
